// File: rtl/wb_uart_slave.sv
// Wishbone classic slave with a 16550-subset register file and 8N1 RX/TX engines.
// Define UART_LOOPBACK_EN to add the MCR register (address 4) with internal TX->RX loopback.
module wb_uart_slave #(
  parameter logic [15:0] DIV_RESET       = 16'd35,
  parameter bit          ERR_ON_UNMAPPED = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        irq_o
);

  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
  localparam logic [15:0] DIV_RESET_EFF = (DIV_RESET == 16'd0) ? 16'd1 : DIV_RESET;

  logic        ack_q, err_q;
  logic [31:0] dat_q;
  logic [7:0]  lcr_q, lcr_d, rbr_q, rbr_d, thr_q, thr_d;
  logic [1:0]  ier_q, ier_d;
  logic [15:0] div_q, div_d, div_eff_d, cnt_q, cnt_d;
  logic        dr_q, dr_d, oe_q, oe_d, fe_q, fe_d, thre_q, thre_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]  rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [3:0]  rx_tick_q, rx_tick_d, tx_tick_q, tx_tick_d;
  logic [2:0]  rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d;
  logic        req, mapped, wr, rd, dlab, tick, rx_in;
  logic        thr_wr, dll_wr, dlm_wr, ier_wr, lcr_wr, rbr_rd, lsr_rd;
  logic        rx_done, rx_stop_bad, tx_load, temt;
  logic [7:0]  iir, lsr, rdata;
  logic        unused_bits;

  assign unused_bits = ^{wb_dat_i[31:8], wb_sel_i[3:1]};

  // Handshake: an access is taken when cyc&stb are high and no ack/err is showing;
  // exactly one ack or err pulse follows on the next edge, together with read data.
  assign req  = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign dlab = lcr_q[7];

  always_comb begin
    mapped = 1'b0;
    case (wb_adr_i)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd5: mapped = 1'b1;
`ifdef UART_LOOPBACK_EN
      3'd4: mapped = 1'b1;
`endif
      default: mapped = 1'b0;
    endcase
  end

  assign wr     = req & wb_we_i & wb_sel_i[0] & mapped;
  assign rd     = req & ~wb_we_i & mapped;
  assign thr_wr = wr & (wb_adr_i == 3'd0) & ~dlab;
  assign dll_wr = wr & (wb_adr_i == 3'd0) & dlab;
  assign ier_wr = wr & (wb_adr_i == 3'd1) & ~dlab;
  assign dlm_wr = wr & (wb_adr_i == 3'd1) & dlab;
  assign lcr_wr = wr & (wb_adr_i == 3'd3);
  assign rbr_rd = rd & (wb_adr_i == 3'd0) & ~dlab;
  assign lsr_rd = rd & (wb_adr_i == 3'd5);

`ifdef UART_LOOPBACK_EN
  logic [4:0] mcr_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) mcr_q <= 5'h00;
    else if (wr && (wb_adr_i == 3'd4)) mcr_q <= wb_dat_i[4:0];
  end
  assign rx_in     = mcr_q[4] ? tx_line_q : uart_rx_i;
  assign uart_tx_o = mcr_q[4] ? 1'b1 : tx_line_q;
`else
  assign rx_in     = uart_rx_i;
  assign uart_tx_o = tx_line_q;
`endif

  assign temt = thre_q & (tx_state_q == TX_IDLE);
  assign lsr  = {1'b0, temt, thre_q, 1'b0, fe_q, 1'b0, oe_q, dr_q};
  assign iir  = (dr_q & ier_q[0]) ? 8'h04 : ((thre_q & ier_q[1]) ? 8'h02 : 8'h01);
  assign irq_o = ~iir[0];

  always_comb begin
    rdata = 8'h00;
    case (wb_adr_i)
      3'd0: rdata = dlab ? div_q[7:0] : rbr_q;
      3'd1: rdata = dlab ? div_q[15:8] : {6'b0, ier_q};
      3'd2: rdata = iir;
      3'd3: rdata = lcr_q;
`ifdef UART_LOOPBACK_EN
      3'd4: rdata = {3'b0, mcr_q};
`endif
      3'd5: rdata = lsr;
      default: rdata = 8'h00;
    endcase
  end

  // Baud generator: any divisor write restarts the count from the new value.
  always_comb begin
    div_d = div_q;
    if (dll_wr) div_d[7:0]  = wb_dat_i[7:0];
    if (dlm_wr) div_d[15:8] = wb_dat_i[7:0];
    div_eff_d = (div_d == 16'd0) ? 16'd1 : div_d;
    tick      = (cnt_q == 16'd0);
    cnt_d     = (dll_wr | dlm_wr | tick) ? (div_eff_d - 16'd1) : (cnt_q - 16'd1);
  end

  always_comb begin
    lcr_d = lcr_wr ? wb_dat_i[7:0] : lcr_q;
    ier_d = ier_wr ? wb_dat_i[1:0] : ier_q;
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tick_d   = rx_tick_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_done     = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_state_d = RX_START;
        rx_tick_d  = 4'd0;
      end
      RX_START: if (tick) begin
        if (rx_tick_q == 4'd7) begin
          rx_tick_d  = 4'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else rx_tick_d = rx_tick_q + 4'd1;
      end
      RX_DATA: if (tick) begin
        if (rx_tick_q == 4'd15) begin
          rx_tick_d  = 4'd0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else rx_tick_d = rx_tick_q + 4'd1;
      end
      RX_STOP: if (tick) begin
        if (rx_tick_q == 4'd15) begin
          rx_tick_d   = 4'd0;
          rx_done     = 1'b1;
          rx_stop_bad = ~rx_sync_q;
          rx_state_d  = RX_IDLE;
        end else rx_tick_d = rx_tick_q + 4'd1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A byte completing alongside an RBR read replaces it cleanly without overrun.
  always_comb begin
    rbr_d = rbr_q;
    dr_d  = dr_q;
    oe_d  = oe_q;
    fe_d  = fe_q;
    if (lsr_rd) begin
      oe_d = 1'b0;
      fe_d = 1'b0;
    end
    if (rbr_rd) dr_d = 1'b0;
    if (rx_done) begin
      rbr_d = rx_shift_q;
      dr_d  = 1'b1;
      if (dr_q && !rbr_rd) oe_d = 1'b1;
      if (rx_stop_bad) fe_d = 1'b1;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (tick && !thre_q) begin
          tx_load    = 1'b1;
          tx_shift_d = thr_q;
          tx_line_d  = 1'b0;
          tx_tick_d  = 4'd0;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tick) begin
        if (tx_tick_q == 4'd15) begin
          tx_tick_d  = 4'd0;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else tx_tick_d = tx_tick_q + 4'd1;
      end
      TX_DATA: if (tick) begin
        if (tx_tick_q == 4'd15) begin
          tx_tick_d = 4'd0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else tx_tick_d = tx_tick_q + 4'd1;
      end
      TX_STOP: if (tick) begin
        if (tx_tick_q == 4'd15) begin
          tx_tick_d  = 4'd0;
          tx_state_d = TX_IDLE;
        end else tx_tick_d = tx_tick_q + 4'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    thr_d  = thr_q;
    thre_d = thre_q;
    if (tx_load) thre_d = 1'b1;
    else if (thr_wr && thre_q) begin
      thr_d  = wb_dat_i[7:0];
      thre_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= 32'h0;
      lcr_q      <= 8'h03;
      ier_q      <= 2'b00;
      div_q      <= DIV_RESET;
      cnt_q      <= DIV_RESET_EFF - 16'd1;
      rbr_q      <= 8'h00;
      thr_q      <= 8'h00;
      dr_q       <= 1'b0;
      oe_q       <= 1'b0;
      fe_q       <= 1'b0;
      thre_q     <= 1'b1;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_line_q  <= 1'b1;
    end else begin
      ack_q      <= req & (mapped | ~ERR_ON_UNMAPPED);
      err_q      <= req & ~mapped & ERR_ON_UNMAPPED;
      if (req && !wb_we_i) dat_q <= {24'h0, rdata};
      lcr_q      <= lcr_d;
      ier_q      <= ier_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      rbr_q      <= rbr_d;
      thr_q      <= thr_d;
      dr_q       <= dr_d;
      oe_q       <= oe_d;
      fe_q       <= fe_d;
      thre_q     <= thre_d;
      rx_meta_q  <= rx_in;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;

endmodule
